// File: rtl/multi_edge_pulse.sv
// rtl/multi_edge_pulse.sv - multi-channel edge-to-pulse converter with overrun flags
// Optional input filter enabled by defining MULTI_EDGE_PULSE_DEBOUNCE_EN.
module multi_edge_pulse #(
    parameter int CH           = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_LEN    = 1,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2*CH-1:0] edge_mode,
    input  logic            overrun_clr,
    input  logic [CH-1:0]   sig_in,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   pulse_out,
    output logic            edge_any,
    output logic [CH-1:0]   overrun
);

    localparam logic [7:0] LEN = 8'(PULSE_LEN);

    if (CH < 1 || CH > 32) begin : g_bad_ch
        $error("CH out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_len
        $error("PULSE_LEN out of range");
    end
    if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255) begin : g_bad_db
        $error("DEBOUNCE_CYC out of range");
    end

    logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
    logic [CH-1:0]                  sync_lvl;
    logic [CH-1:0]                  prev;
    logic [CH-1:0]                  ev;
    logic [CH-1:0][7:0]             cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sig_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_PULSE_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYC - 1);

    logic [CH-1:0][7:0] db_cnt;
    logic [CH-1:0]      lvl_q;

    // A level change is accepted only after it has persisted DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            lvl_q  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync_lvl[i] == lvl_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl_q[i]  <= sync_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign level_out = lvl_q;
`else
    assign level_out = sync_lvl;
`endif

    // prev keeps tracking while disabled so re-enabling never sees a stale edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else begin
            prev <= level_out;
        end
    end

    always_comb begin
        ev = '0;
        for (int i = 0; i < CH; i++) begin
            ev[i] = en & ((edge_mode[2*i]   &  level_out[i] & ~prev[i]) |
                          (edge_mode[2*i+1] & ~level_out[i] &  prev[i]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            overrun  <= '0;
            edge_any <= 1'b0;
        end else begin
            edge_any <= |ev;
            for (int i = 0; i < CH; i++) begin
                if (!en) begin
                    cnt[i] <= '0;
                end else if (ev[i] && cnt[i] == 8'd0) begin
                    cnt[i] <= LEN;
                end else if (cnt[i] != 8'd0) begin
                    cnt[i] <= cnt[i] - 8'd1;
                end
                // A dropped event outranks a same-cycle clear.
                if (ev[i] && cnt[i] != 8'd0) begin
                    overrun[i] <= 1'b1;
                end else if (overrun_clr) begin
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pulse_out = '0;
        for (int i = 0; i < CH; i++) begin
            pulse_out[i] = (cnt[i] != 8'd0);
        end
    end

endmodule

// File: doc/multi_edge_pulse.md
# multi_edge_pulse

Parametrised multi-channel edge-to-pulse converter. Each channel synchronises an asynchronous level input, detects rising, falling or both edges per a runtime mode, and emits a pulse of programmable length. Pulses that arrive while a channel is still stretching are counted as overruns. The block sits between raw GPIO/status inputs and the control logic that consumes single-event strobes.

## Interface
- CH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- PULSE_LEN, 1: `pulse_out` high time in clk cycles (1..255); counter width is 8 bits.
- DEBOUNCE_CYC, 4: stable cycles required before a level change is accepted (1..255). Used only when `MULTI_EDGE_PULSE_DEBOUNCE_EN` is defined.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable for event generation.
- edge_mode  in  2*CH  per channel `[2i+1:2i]`: 00 off, 01 rising, 10 falling, 11 both.
- overrun_clr  in  1  clears all `overrun` bits; synchronous, single cycle.
- sig_in  in  CH  asynchronous level inputs.
- level_out  out  CH  synchronised (and filtered) level per channel.
- pulse_out  out  CH  stretched edge pulse per channel.
- edge_any  out  1  registered OR of all enabled-mode events, high for 1 cycle.
- overrun  out  CH  sticky: an event was dropped because the channel was still stretching.

## Operation
- Reset values: all synchroniser, filter, previous-level and stretch-counter flops are 0. `level_out`, `pulse_out`, `edge_any` and `overrun` are all 0.
- Synchroniser: a shift chain of SYNC_STAGES flops per channel. The last stage gives `sync_lvl`.
- Filter: without the macro, `level_out = sync_lvl`. With the macro, see Configuration.
- Previous level: `prev` is `level_out` delayed one cycle. `rise = level_out & ~prev` and `fall = ~level_out & prev`.
- Event: `ev[i] = en & ((mode[0] & rise) | (mode[1] & fall))`. This is combinational from the current `edge_mode`, so a mode change takes effect immediately.
- Stretcher, per channel, 8-bit `cnt`:
  - if `!en`: `cnt <= 0`;
  - else if `ev` and `cnt == 0`: `cnt <= PULSE_LEN`;
  - else if `cnt != 0`: `cnt <= cnt - 1`.
  - `pulse_out = (cnt != 0)`.
- Overrun: `ev & (cnt != 0)` drops the event, with no retrigger and no extension, and sets `overrun[i]`.
  - `overrun_clr` clears the bit. If a set and a clear land in the same cycle, set wins.
  - `overrun` holds its value while `en = 0`.
- `edge_any <= |ev` every cycle. It includes dropped events.
- `en = 0` does not stop the synchroniser, filter or `prev`. Re-enabling therefore never generates a stale edge.
- An input already high at reset release produces a rising edge once it propagates, because the flops reset to 0.

## Timing
- Edge 0 is the rising edge that first samples a new `sig_in` value.
- `level_out` changes at edge SYNC_STAGES-1. With the macro, it changes at edge SYNC_STAGES-1+DEBOUNCE_CYC.
- `pulse_out` and `edge_any` rise at edge SYNC_STAGES, or SYNC_STAGES+DEBOUNCE_CYC with the macro.
- `pulse_out` stays high for exactly PULSE_LEN cycles.
- The minimum event spacing without overrun is PULSE_LEN+1 cycles.
- `en` falling: `pulse_out` clears at the next edge.
- Reset asserted mid-pulse: all outputs go to 0 immediately (asynchronous).

## Configuration
- `MULTI_EDGE_PULSE_DEBOUNCE_EN` defined:
  - adds an 8-bit counter per channel;
  - the counter increments while `sync_lvl != level_out` and clears when they are equal;
  - when it reaches DEBOUNCE_CYC-1 while the mismatch persists, `level_out` flips and the counter clears;
  - glitches shorter than DEBOUNCE_CYC cycles are rejected.
- Undefined: no counter, `level_out = sync_lvl`, and DEBOUNCE_CYC is ignored.

## Test plan
- Rising, no debounce:
  - Setup: CH=4, SYNC_STAGES=2, PULSE_LEN=1, mode 01 on ch0.
  - Stimulus: `sig_in[0]` 0->1 sampled at edge 0.
  - Required: `pulse_out[0]` and `edge_any` are high for edge 2 only, and `level_out[0]` goes 1 at edge 1.
- Both edges and stretch:
  - Setup: PULSE_LEN=5, mode 11 on ch1.
  - Stimulus: rise, then fall 10 cycles later.
  - Required: two 5-cycle pulses and `overrun[1]` stays 0.
- Overrun:
  - Setup: PULSE_LEN=5, mode 11.
  - Stimulus: fall 3 cycles after rise.
  - Required: a single 5-cycle pulse, `overrun` set and `edge_any` high twice. `overrun_clr` then returns it to 0.
- Enable gating:
  - Stimulus: `en = 0` mid-pulse.
  - Required: `pulse_out` is 0 at the next edge. Toggling input while disabled and then setting `en = 1` with a stable input gives no pulse.
- Mode off / falling only:
  - Setup: ch2 in mode 00, ch3 in mode 10.
  - Stimulus: pulse the input 0->1->0 on both channels.
  - Required: ch2 gives nothing; ch3 pulses only on 1->0.
- Debounce (macro defined, DEBOUNCE_CYC=4):
  - Stimulus: a 3-cycle glitch, then a stable rise.
  - Required: the glitch is ignored; the stable rise gives `pulse_out` at edge 6. Reset asserted mid-count returns all outputs to 0.
